// File: rtl/multi_channel_freq_decoder.sv
// -----------------------------------------------------------------------------
// multi_channel_freq_decoder
//
// Regenerates one 50 %-duty square wave per channel from WIDTH-bit frequency
// codes delivered over a valid/ready write port. A larger code gives a shorter
// half-period: H(C) = (2^WIDTH - 1) - C. The all-ones code stops a channel
// (output forced low) and the all-zeros code freezes it at its current level.
// A new code for a running channel is parked in a one-deep pending slot and
// only applied on the edge where the half-period counter reaches 1, so the
// output never produces a short pulse when the frequency changes.
//
// Ports
//   clk         in   1         single clock, all state on the rising edge
//   rst_n       in   1         asynchronous active-low reset
//   ena         in   1         global enable; low freezes every channel
//   code_in     in   WIDTH     encoded frequency code
//   code_ch     in   CH_W      channel addressed by code_in
//   code_valid  in   1         write request
//   code_ready  out  1         write can be accepted this cycle (combinational)
//   freq_out    out  CHANNELS  regenerated square wave per channel
//   active      out  CHANNELS  channel currently generating (RUN state)
// -----------------------------------------------------------------------------
module multi_channel_freq_decoder #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CH_W     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [WIDTH-1:0]    code_in,
    input  logic [CH_W-1:0]     code_ch,
    input  logic                code_valid,
    output logic                code_ready,
    output logic [CHANNELS-1:0] freq_out,
    output logic [CHANNELS-1:0] active
);

    localparam logic [WIDTH-1:0] CODE_STOP = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CODE_HOLD = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Half-period length for a running code; only called for codes that are
    // neither all-ones nor all-zeros, so the result is always at least 1.
    function automatic logic [WIDTH-1:0] half_period(input logic [WIDTH-1:0] code);
        return CODE_STOP - code;
    endfunction

    // Per-channel state.
    state_e             state_q     [CHANNELS];
    state_e             state_d     [CHANNELS];
    logic [WIDTH-1:0]   cnt_q       [CHANNELS];
    logic [WIDTH-1:0]   cnt_d       [CHANNELS];
    logic [WIDTH-1:0]   cur_code_q  [CHANNELS];
    logic [WIDTH-1:0]   cur_code_d  [CHANNELS];
    logic [WIDTH-1:0]   pend_code_q [CHANNELS];
    logic [WIDTH-1:0]   pend_code_d [CHANNELS];
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] pend_valid_q;
    logic [CHANNELS-1:0] pend_valid_d;

    // Write-port decode.
    logic [31:0]         ch_idx_s;
    logic                ch_in_range_s;
    logic                ch_busy_s;
    logic [CHANNELS-1:0] wr_sel_s;
    logic                wr_en_s;
    logic [CHANNELS-1:0] apply_s;

    // Decode the addressed channel and derive the handshake. An address beyond
    // the last channel is always ready so the writer never stalls; the data is
    // simply dropped because no channel's select bit matches.
    always_comb begin
        ch_idx_s      = 32'(code_ch);
        ch_in_range_s = (ch_idx_s < CHANNELS);
        ch_busy_s     = 1'b0;
        wr_sel_s      = {CHANNELS{1'b0}};
        for (int i = 0; i < int'(CHANNELS); i++) begin
            wr_sel_s[i] = (ch_idx_s == 32'(i));
            ch_busy_s   = ch_busy_s | (wr_sel_s[i] & pend_valid_q[i]);
        end
        code_ready = ena & (~ch_in_range_s | ~ch_busy_s);
        wr_en_s    = code_valid & code_ready;
    end

    // Next-state logic for every channel: apply a pending code, otherwise
    // advance the half-period counter, then capture a newly accepted code.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_code_d   = cur_code_q;
        pend_code_d  = pend_code_q;
        out_d        = out_q;
        pend_valid_d = pend_valid_q;
        apply_s      = {CHANNELS{1'b0}};

        for (int i = 0; i < int'(CHANNELS); i++) begin
            // Idle channels take a pending code immediately; a running one
            // waits for its boundary edge so the current half-period completes.
            apply_s[i] = pend_valid_q[i] &
                         ((state_q[i] != ST_RUN) | (cnt_q[i] == CNT_ONE));

            if (ena) begin
                if (apply_s[i]) begin
                    pend_valid_d[i] = 1'b0;
                    cur_code_d[i]   = pend_code_q[i];
                    if (pend_code_q[i] == CODE_STOP) begin
                        state_d[i] = ST_OFF;
                        out_d[i]   = 1'b0;
                        cnt_d[i]   = CNT_ZERO;
                    end else if (pend_code_q[i] == CODE_HOLD) begin
                        // Freeze: level and counter are kept as they are.
                        state_d[i] = ST_HOLD;
                    end else begin
                        state_d[i] = ST_RUN;
                        cnt_d[i]   = half_period(pend_code_q[i]);
                        case (state_q[i])
                            ST_OFF:  out_d[i] = 1'b0;
                            // The boundary toggle still happens on a rate change.
                            ST_RUN:  out_d[i] = ~out_q[i];
                            ST_HOLD: out_d[i] = out_q[i];
                            default: out_d[i] = 1'b0;
                        endcase
                    end
                end else if (state_q[i] == ST_RUN) begin
                    if (cnt_q[i] == CNT_ONE) begin
                        out_d[i] = ~out_q[i];
                        cnt_d[i] = half_period(cur_code_q[i]);
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end else begin
                    state_d[i] = state_q[i];
                end

                // Acceptance implies the slot was empty, so this never collides
                // with an apply on the same channel in the same cycle.
                if (wr_en_s & wr_sel_s[i]) begin
                    pend_valid_d[i] = 1'b1;
                    pend_code_d[i]  = code_in;
                end else begin
                    pend_code_d[i]  = pend_code_d[i];
                end
            end else begin
                state_d[i] = state_q[i];
            end
        end
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i]     <= ST_OFF;
                cnt_q[i]       <= CNT_ZERO;
                cur_code_q[i]  <= CODE_STOP;
                pend_code_q[i] <= CODE_STOP;
            end
            out_q        <= {CHANNELS{1'b0}};
            pend_valid_q <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i]     <= state_d[i];
                cnt_q[i]       <= cnt_d[i];
                cur_code_q[i]  <= cur_code_d[i];
                pend_code_q[i] <= pend_code_d[i];
            end
            out_q        <= out_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Outputs are taken straight from registered state, so they are glitch-free
    // and drop to zero the moment reset asserts.
    always_comb begin
        freq_out = out_q;
        active   = {CHANNELS{1'b0}};
        for (int i = 0; i < int'(CHANNELS); i++) begin
            active[i] = (state_q[i] == ST_RUN);
        end
    end

endmodule

// File: doc/multi_channel_freq_decoder.md
# multi_channel_freq_decoder

Parametrised successor to the single-channel frequency decoder. It accepts WIDTH-bit encoded frequency codes over a valid/ready write port, addressed to one of CHANNELS channels. Each channel regenerates a 50 %-duty square wave whose frequency rises with the code. The all-ones code stops a channel and the all-zeros code freezes it. Code changes on a running channel apply only at a half-period boundary, so outputs are glitch-free. The block sits between the encoder path and the chip output pins.

## Interface
Parameters:
- WIDTH, 8, code width in bits (≥2)
- CHANNELS, 2, number of independent output channels (≥1)
- CH_W, 1, width of the channel-select field (≥1, 2^CH_W ≥ CHANNELS)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  global enable; low freezes all state
- code_in  in  WIDTH  encoded frequency code
- code_ch  in  CH_W  target channel of code_in
- code_valid  in  1  write request
- code_ready  out  1  write can be accepted (combinational)
- freq_out  out  CHANNELS  regenerated square wave per channel
- active  out  CHANNELS  channel in RUN state

## Operation
- Per-channel state: state ∈ {OFF, RUN, HOLD}, out bit, cnt[WIDTH-1:0], cur_code, pend_code, pend_valid.
- Half-period H(C) = (2^WIDTH − 1) − C, evaluated for C in 1..2^WIDTH−2. H ranges from 1 to 2^WIDTH−2. Output period is 2·H cycles.
- Handshake rules:
  - code_ready = ena && !pend_valid[code_ch] when code_ch < CHANNELS.
  - code_ready = ena when code_ch ≥ CHANNELS; the transfer is accepted and discarded.
- Transfer: code_valid && code_ready at an edge sets pend_code/pend_valid of the target channel. code_valid may drop at any time; a transfer occurs only when code_ready is high.
- Applying a pending code:
  - In OFF or HOLD, it applies on the edge after acceptance.
  - In RUN, it applies on the boundary edge, i.e. the edge where cnt == 1.
  - Applying clears pend_valid and sets cur_code.
- Effect of an applied code C:
  - C all-ones: go to OFF, out = 0, cnt = 0.
  - C zero: go to HOLD. out and cnt are retained.
  - Otherwise: go to RUN and load cnt = H(C).
    - From OFF, out = 0.
    - From HOLD, out is retained.
    - From RUN at the boundary, out toggles.
- RUN with nothing to apply: cnt decrements each enabled edge. When cnt == 1: out toggles and cnt reloads H(cur_code).
- active[i] = (state_i == RUN). freq_out[i] = out_i.
- ena low: no state changes, code_ready = 0, and outputs hold their values.
- Writes to different channels on consecutive cycles are independent.
- A write arriving in the same cycle the same channel applies its pending code is refused, because pend_valid is still 1. It can be accepted the following cycle.

## Timing
- Reset (async assert, sync-safe release), all channels:
  - state = OFF, freq_out = 0, active = 0, cnt = 0, pend_valid = 0, cur_code = all-ones.
  - code_ready = ena after reset.
- Latency from OFF: code accepted at edge t; applied at edge t+1 (active rises); first freq_out rise at edge t+1+H.
- Latency in RUN: a new code takes effect at the next boundary. The worst case is H(old) edges after acceptance. The toggle at that boundary still occurs, and the next half-period uses H(new).
- HOLD → RUN resumes from the retained out level; the first toggle comes H(new) edges after the apply edge.
- Asserting rst_n low mid-run forces all outputs to 0 immediately, without waiting for clk.

## Test plan
- Reset/idle: hold rst_n=0, then release with ena=1 → freq_out=0, active=0, code_ready=1; nothing changes for 100 cycles.
- Fastest/period check (WIDTH=8): write 254 to ch0, then 250 to ch1 → ch0 toggles every cycle; ch1 has H=5 and period 10, first rise 6 edges after acceptance; active=2'b11.
- Boundary update: ch0 running code 250; write 252 (H=3) mid half-period → change applies only at the cnt==1 edge, with no glitch. A second write before apply sees code_ready=0 for ch0 only.
- Hold and stop:
  - Write 0 to ch0 while freq_out[0]=1 → stays 1 and active drops at the boundary.
  - Then write 253 → resumes from 1 with H=2.
  - Then write 255 → freq_out[0]=0 and active=0 at the next boundary.
- Enable/out-of-range: drop ena for 7 cycles mid-run → outputs and counters frozen, code_ready=0. A write to code_ch=3 with CHANNELS=2 is accepted and has no effect.
- Reset mid-operation: assert rst_n between clock edges while both channels run → outputs go to 0 asynchronously. After release, behaviour is identical to the first scenario.
